mc_mem_port: RTL and testbench

Memory-access stage between the multicycle controller and the single unified instruction/data memory. It turns the controller's level-style `memread`/`memwrite`/`IorD`/`IR_write` strobes into a registered req/ack bus transaction and stalls the controller with `mem_wait` until the access completes. On completion it latches read data into the instruction register (IR) and/or the memory data register (MDR).

---
 rtl/mc_pkg.sv | 14 +
 rtl/mc_mem_port_if.sv | 26 ++
 rtl/mc_mem_timeout.sv | 43 ++++
 rtl/mc_mem_port.sv | 155 +++++++++++++++
 tb/tb_mc_mem_port.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller memory path.
// Contents: default bus widths and the memory-port FSM state type.
package mc_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mc_mem_port_if.sv
// Request/acknowledge bus between the memory port and the unified memory.
// master: drives mem_req, mem_we, mem_addr, mem_wdata; receives mem_ack, mem_rdata.
// slave : the memory side of the same bus.
interface mc_mem_port_if #(
  parameter int unsigned ADDR_W = mc_pkg::ADDR_W,
  parameter int unsigned DATA_W = mc_pkg::DATA_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mc_mem_timeout.sv
// BUSY-cycle counter for the memory port's bus timeout.
// Ports: clk, reset (async, active-high)
//   clear_i     - hold the count at zero (port not in BUSY)
//   busy_i      - port is waiting for an ack this cycle
//   ack_i       - bus acknowledge this cycle
//   expired_c_o - combinational: this no-ack cycle brings the count to TIMEOUT
module mc_mem_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count each BUSY cycle that ends without an ack.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (busy_i && !ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the reaching cycle suppresses expiry.
  assign expired_c_o = busy_i && !ack_i && (cnt_d == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mc_mem_port.sv
// Memory-access stage: turns the controller's memread/memwrite strobes into a
// registered req/ack bus transaction, stalls the controller with mem_wait, and
// latches read data into IR and/or MDR on completion.
// Ports: clk, reset (async, active-high)
//   memread, memwrite, IorD, IR_write, pc, alu_out, wdata - controller side
//   mem_wait (combinational stall), mem_done (completion pulse), ir, mdr
//   bus_error - sticky timeout flag (always 0 unless MC_MEM_TIMEOUT_EN)
//   bus       - mc_mem_port_if.master: mem_req/mem_we/mem_addr/mem_wdata out,
//               mem_ack/mem_rdata in
// Build option: define MC_MEM_TIMEOUT_EN to abort BUSY after TIMEOUT no-ack cycles.
module mc_mem_port
  import mc_pkg::*;
#(
  parameter int unsigned ADDR_W  = mc_pkg::ADDR_W,
  parameter int unsigned DATA_W  = mc_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              IorD,
  input  logic              IR_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_wait,
  output logic              mem_done,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_error,
  mc_mem_port_if.master     bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mc_mem_port: TIMEOUT must be at least 1");
  end

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              we_q, we_d;
  logic              irw_q, irw_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              expired_c;

`ifdef MC_MEM_TIMEOUT_EN
  mc_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (state_q == IDLE),
    .busy_i      (state_q == BUSY),
    .ack_i       (bus.mem_ack),
    .expired_c_o (expired_c)
  );
`else
  assign expired_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    irw_d   = irw_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (memread || memwrite) begin
          // Write takes priority when both strobes are high.
          addr_d  = IorD ? alu_out : pc;
          we_d    = memwrite;
          wdata_d = wdata;
          irw_d   = IR_write;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            mdr_d = bus.mem_rdata;
            if (irw_q) begin
              ir_d = bus.mem_rdata;
            end
          end
        end else if (expired_c) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      irw_q   <= irw_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Stall is combinational so the controller freezes in the request cycle itself.
  assign mem_wait = ((state_q == IDLE) && (memread || memwrite)) || (state_q == BUSY);

  assign mem_done      = done_q;
  assign ir            = ir_q;
  assign mdr           = mdr_q;
  assign bus_error     = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mc_mem_port.sv
// Scoreboard bench for mc_mem_port: the stimulus side pushes the expected bus
// command and IR/MDR/error outcome per access; a negedge monitor acts as the
// memory (acks after a chosen number of BUSY cycles) and checks the bus and
// completion against the queue head.
module tb_mc_mem_port;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          memread = 1'b0, memwrite = 1'b0, IorD = 1'b0, IR_write = 1'b0;
  logic [AW-1:0] pc = '0, alu_out = '0;
  logic [DW-1:0] wdata = '0;
  logic          mem_wait, mem_done, bus_error;
  logic [DW-1:0] ir, mdr;

  mc_mem_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mc_mem_port #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .IorD      (IorD),
    .IR_write  (IR_write),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .mem_wait  (mem_wait),
    .mem_done  (mem_done),
    .ir        (ir),
    .mdr       (mdr),
    .bus_error (bus_error),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            ack_k;      // BUSY cycle (1-based) in which the memory acks
    logic [DW-1:0] rdata;
    logic [DW-1:0] ir;
    logic [DW-1:0] mdr;
    logic          err;
    int            req_cycles; // cycles mem_req must stay high
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            busy_cnt = 0;
  bit            mon_en = 1'b0;
  bit            b2b_prev = 1'b0;
  logic [DW-1:0] m_ir = '0, m_mdr = '0;
  logic          m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Memory model and checker, evaluated mid-cycle.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("mem_wait", mem_wait, ((memread || memwrite) && !mem_done) || bus.mem_req);
      if (mem_done) begin
        chk("done_without_req", bus.mem_req, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got mem_done=1 expected no access pending");
        end else begin
          mon_e = exp_q.pop_front();
          chk("ir", ir, mon_e.ir);
          chk("mdr", mdr, mon_e.mdr);
          chk("bus_error", bus_error, mon_e.err);
          chk("req_cycles", 64'(busy_cnt), 64'(mon_e.req_cycles));
        end
      end
      if (bus.mem_req) begin
        busy_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got mem_req=1 expected no access pending");
          bus.mem_ack = 1'b0;
        end else begin
          chk("mem_addr", bus.mem_addr, exp_q[0].addr);
          chk("mem_we", bus.mem_we, exp_q[0].we);
          chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
          if (busy_cnt == exp_q[0].ack_k) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = exp_q[0].rdata;
          end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
          end
        end
      end else begin
        busy_cnt = 0;
        // Stray acks outside BUSY must be ignored.
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
    end
  end

  // One controller access; k > TO models a memory that never answers.
  task automatic txn(input bit rd, input bit wr, input bit iord, input bit irw,
                     input logic [AW-1:0] pcv, input logic [AW-1:0] alu,
                     input logic [DW-1:0] wd, input int k, input logic [DW-1:0] rdv,
                     input int gap);
    exp_t e;
    bit   to = 1'b0;
    bit   got = 1'b0;
    int   n = 0;
`ifdef MC_MEM_TIMEOUT_EN
    to = (k > int'(TO));
`endif
    e.addr  = iord ? alu : pcv;
    e.we    = wr;
    e.wdata = wd;
    e.ack_k = k;
    e.rdata = rdv;
    if (to) begin
      m_err        = 1'b1;
      e.req_cycles = int'(TO);
    end else begin
      e.req_cycles = k;
      if (!wr) begin
        m_mdr = rdv;
        if (irw) m_ir = rdv;
      end
    end
    e.ir  = m_ir;
    e.mdr = m_mdr;
    e.err = m_err;
    exp_q.push_back(e);
    memread  = rd;
    memwrite = wr;
    IorD     = iord;
    IR_write = irw;
    pc       = pcv;
    alu_out  = alu;
    wdata    = wd;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (mem_done) begin
        got = 1'b1;
        n   = i;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no mem_done expected one within 200 cycles");
    end else begin
      chk("done_latency", 64'(n), 64'(e.req_cycles + 1 + (b2b_prev ? 1 : 0)));
    end
    b2b_prev = (gap == 0);
    if (gap > 0) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_txns(input int count);
    int op;
    for (int i = 0; i < count; i++) begin
      op = int'($urandom_range(0, 2));
      txn(op != 1, op != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom, int'($urandom_range(1, TO)), $urandom,
          int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    exp_t h;
    #1000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
    h = '{default: '0};
  end

  initial begin
    exp_t h;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_mem_done", mem_done, 1'b0);
    chk("rst_mem_wait", mem_wait, 1'b0);
    chk("rst_ir", ir, '0);
    chk("rst_mdr", mdr, '0);
    chk("rst_bus_error", bus_error, 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Fetch, ack in first BUSY cycle.
    txn(1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 1, 32'h8C22_0004, 1);
    // Load with ack in the third BUSY cycle, followed back-to-back by a store.
    txn(1, 0, 1, 0, 32'h44, 32'h104, 32'h0, 3, 32'h1234_5678, 0);
    txn(0, 1, 1, 0, 32'h48, 32'h200, 32'hDEAD_BEEF, 2, 32'hAAAA_5555, 1);
    // Both strobes: treated as a write.
    txn(1, 1, 0, 1, 32'h4C, 32'h300, 32'hCAFE_F00D, 1, 32'h5555_AAAA, 0);
    // Ack in the same cycle the timeout count is reached still completes normally.
    txn(1, 0, 1, 1, 32'h50, 32'h310, 32'h0, int'(TO), 32'h0BAD_CAFE, 1);
    rand_txns(30);

    // Reset in the middle of an access that is never acknowledged.
    h = '{addr: 32'h400, we: 1'b0, wdata: 32'h0, ack_k: 100000, rdata: '0,
          ir: m_ir, mdr: m_mdr, err: m_err, req_cycles: 0};
    exp_q.push_back(h);
    memread = 1'b1; memwrite = 1'b0; IorD = 1'b1; IR_write = 1'b1;
    alu_out = 32'h400; pc = 32'h60; wdata = 32'h0;
`ifdef MC_MEM_TIMEOUT_EN
    repeat (2) @(posedge clk);
    #1;
    chk("busy_before_timeout", bus.mem_req, 1'b1);
`else
    repeat (100) @(posedge clk);
    #1;
    chk("hang_mem_wait", mem_wait, 1'b1);
    chk("hang_mem_req", bus.mem_req, 1'b1);
`endif
    memread = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_mem_req", bus.mem_req, 1'b0);
    chk("midrst_mem_wait", mem_wait, 1'b0);
    chk("midrst_mem_done", mem_done, 1'b0);
    chk("midrst_ir", ir, '0);
    chk("midrst_mdr", mdr, '0);
    chk("midrst_bus_error", bus_error, 1'b0);
    exp_q.delete();
    m_ir = '0; m_mdr = '0; m_err = 1'b0; b2b_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    txn(1, 0, 0, 1, 32'h80, 32'h0, 32'h0, 2, 32'h1357_9BDF, 1);
`ifdef MC_MEM_TIMEOUT_EN
    // Memory never answers: completion after TO BUSY cycles with bus_error set.
    txn(1, 0, 1, 1, 32'h84, 32'h500, 32'h0, 100000, 32'hFFFF_FFFF, 1);
    chk("bus_error_sticky", bus_error, 1'b1);
`endif
    rand_txns(10);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
